// File: rtl/fetch_decode_queue_if.sv
// fetch_decode_queue_if: bundle of the fetch-side handshake, the decode-side
// stall/flush controls and the registered decode-stage outputs.
//   master : fetch/decode environment (drives F_*, stall_D, MEM_stall, EX_taken)
//   slave  : fetch_decode_queue (drives F_ready, D_*, count)
interface fetch_decode_queue_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_BITS = 12,
    parameter int unsigned DEPTH   = 4
);
    localparam int unsigned CountW = $clog2(DEPTH + 1);

    // Fetch side
    logic               F_valid;
    logic               F_ready;
    logic [PC_BITS-1:0] F_pc;
    logic [XLEN-1:0]    F_inst;
    logic               F_BP_taken;
    logic [PC_BITS-1:0] F_BP_target_pc;
    logic [XLEN-1:0]    F_link_addr;

    // Pipeline control
    logic               stall_D;
    logic               MEM_stall;
    logic               EX_taken;

    // Decode side
    logic               D_valid;
    logic [PC_BITS-1:0] D_pc;
    logic [XLEN-1:0]    D_inst;
    logic               D_BP_taken;
    logic [PC_BITS-1:0] D_BP_target_pc;
    logic [XLEN-1:0]    D_link_addr;
    logic [CountW-1:0]  count;

    modport master (
        output F_valid, F_pc, F_inst, F_BP_taken, F_BP_target_pc, F_link_addr,
        output stall_D, MEM_stall, EX_taken,
        input  F_ready,
        input  D_valid, D_pc, D_inst, D_BP_taken, D_BP_target_pc, D_link_addr, count
    );

    modport slave (
        input  F_valid, F_pc, F_inst, F_BP_taken, F_BP_target_pc, F_link_addr,
        input  stall_D, MEM_stall, EX_taken,
        output F_ready,
        output D_valid, D_pc, D_inst, D_BP_taken, D_BP_target_pc, D_link_addr, count
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular queue of up to DEPTH fetched instructions (with
// branch-prediction metadata) in front of a registered decode-output stage.
// Fetch sees a ready/valid handshake; EX_taken flushes queue and output stage.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : fetch_decode_queue_if.slave
//          F_* in, F_ready out (combinational from count only),
//          stall_D / MEM_stall / EX_taken in, D_* and count out (registered)
module fetch_decode_queue #(
    parameter int unsigned     XLEN    = 32,
    parameter int unsigned     PC_BITS = 12,
    parameter int unsigned     DEPTH   = 4,
    parameter logic [XLEN-1:0] NOP     = XLEN'(32'h2000_0000)
) (
    input logic                  clk,
    input logic                  rst,
    fetch_decode_queue_if.slave  bus
);

    localparam int unsigned       CountW    = $clog2(DEPTH + 1);
    localparam int unsigned       PtrW      = $clog2(DEPTH);
    localparam logic [CountW-1:0] CountFull = CountW'(DEPTH);
    localparam logic [PtrW-1:0]   PtrLast   = PtrW'(DEPTH - 1);

    typedef struct packed {
        logic [PC_BITS-1:0] pc;
        logic [XLEN-1:0]    inst;
        logic               bp_taken;
        logic [PC_BITS-1:0] bp_target_pc;
        logic [XLEN-1:0]    link_addr;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              d_valid_q, d_valid_d;
    entry_t            d_entry_q, d_entry_d;

    entry_t f_entry;
    entry_t bubble_entry;
    logic   f_ready;
    logic   advance;
    logic   push;
    logic   pop;
    logic   bypass;
    logic   store;
    logic   queue_empty;
    logic   wr_en;

    // Wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        f_entry = '{
            pc:           bus.F_pc,
            inst:         bus.F_inst,
            bp_taken:     bus.F_BP_taken,
            bp_target_pc: bus.F_BP_target_pc,
            link_addr:    bus.F_link_addr
        };
        bubble_entry = '{
            pc:           '0,
            inst:         NOP,
            bp_taken:     1'b0,
            bp_target_pc: '0,
            link_addr:    '0
        };

        // F_ready looks only at registered count: a full queue refuses a push
        // even in a cycle where it also pops.
        f_ready     = (count_q != CountFull);
        queue_empty = (count_q == '0);
        advance     = ~bus.stall_D & ~bus.MEM_stall;
        push        = bus.F_valid & f_ready;
        pop         = advance & ~queue_empty;
        bypass      = advance & queue_empty & push;
        store       = push & ~bypass;

        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        d_valid_d = d_valid_q;
        d_entry_d = d_entry_q;
        wr_en     = 1'b0;

        if (bus.EX_taken) begin
            // Flush wins over stalls; a same-cycle push is dropped.
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            d_valid_d = 1'b0;
            d_entry_d = bubble_entry;
        end else begin
            if (pop) begin
                d_valid_d = 1'b1;
                d_entry_d = mem_q[rd_ptr_q];
                rd_ptr_d  = ptr_inc(rd_ptr_q);
            end else if (bypass) begin
                d_valid_d = 1'b1;
                d_entry_d = f_entry;
            end else if (advance) begin
                d_valid_d = 1'b0;
                d_entry_d = bubble_entry;
            end

            if (store) begin
                wr_en    = ~rst;
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end

            count_d = count_q + CountW'(store) - CountW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            d_valid_q <= 1'b0;
            d_entry_q <= bubble_entry;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            d_valid_q <= d_valid_d;
            d_entry_q <= d_entry_d;
        end
    end

    // Storage needs no reset: only entries covered by count are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= f_entry;
        end
    end

    assign bus.F_ready        = f_ready;
    assign bus.D_valid        = d_valid_q;
    assign bus.D_pc           = d_entry_q.pc;
    assign bus.D_inst         = d_entry_q.inst;
    assign bus.D_BP_taken     = d_entry_q.bp_taken;
    assign bus.D_BP_target_pc = d_entry_q.bp_target_pc;
    assign bus.D_link_addr    = d_entry_q.link_addr;
    assign bus.count          = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed test of fetch_decode_queue at DEPTH = 4
// (bypass, stall fill, full-queue refusal, flush, bubble, metadata) and at
// DEPTH = 3 (pointer wrap under alternating stalls, mid-stream reset).
module tb_fetch_decode_queue;

    localparam logic [31:0] NOP = 32'h2000_0000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_decode_queue_if #(.XLEN(32), .PC_BITS(12), .DEPTH(4)) qa ();
    fetch_decode_queue_if #(.XLEN(32), .PC_BITS(12), .DEPTH(3)) qb ();

    fetch_decode_queue #(.XLEN(32), .PC_BITS(12), .DEPTH(4), .NOP(NOP)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (qa.slave)
    );

    fetch_decode_queue #(.XLEN(32), .PC_BITS(12), .DEPTH(3), .NOP(NOP)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (qb.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [11:0] pc, input logic bp,
                           input logic [11:0] tgt, input logic [31:0] link);
        qa.F_valid        = v;
        qa.F_pc           = pc;
        qa.F_inst         = 32'hA000_0000 | 32'(pc);
        qa.F_BP_taken     = bp;
        qa.F_BP_target_pc = tgt;
        qa.F_link_addr    = link;
    endtask

    // DEPTH = 3 wrap sequence, hand-computed.
    int          st_b   [13] = '{1, 1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    int          fv_b   [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int          dv_b   [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    logic [11:0] dpc_b  [13] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h200, 12'h204,
                                 12'h204, 12'h208, 12'h208, 12'h20C, 12'h210, 12'h214,
                                 12'h218};
    int          cnt_b  [13] = '{1, 2, 3, 3, 2, 2, 3, 2, 3, 2, 2, 2, 1};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        drive_a(1'b0, 12'h0, 1'b0, 12'h0, 32'h0);
        qa.stall_D   = 1'b0;
        qa.MEM_stall = 1'b0;
        qa.EX_taken  = 1'b0;
        qb.F_valid   = 1'b0;
        qb.F_pc      = '0;
        qb.F_inst    = '0;
        qb.F_BP_taken     = 1'b0;
        qb.F_BP_target_pc = '0;
        qb.F_link_addr    = '0;
        qb.stall_D   = 1'b0;
        qb.MEM_stall = 1'b0;
        qb.EX_taken  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        check("rst_d_valid", 32'(qa.D_valid), 32'd0);
        check("rst_d_inst",  qa.D_inst, NOP);
        check("rst_d_pc",    32'(qa.D_pc), 32'h0);
        check("rst_count",   32'(qa.count), 32'd0);
        check("rst_f_ready", 32'(qa.F_ready), 32'd1);

        // Bypass stream, no stalls
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 12'(4 * i), 1'b0, 12'h0, 32'h0);
            tick();
            check("byp_d_pc",    32'(qa.D_pc), 32'(4 * i));
            check("byp_d_valid", 32'(qa.D_valid), 32'd1);
            check("byp_d_inst",  qa.D_inst, 32'hA000_0000 | 32'(4 * i));
            check("byp_count",   32'(qa.count), 32'd0);
        end

        // Bubble on empty queue
        drive_a(1'b0, 12'h0, 1'b0, 12'h0, 32'h0);
        tick();
        check("bub_d_valid", 32'(qa.D_valid), 32'd0);
        check("bub_d_inst",  qa.D_inst, NOP);
        check("bub_d_pc",    32'(qa.D_pc), 32'h0);

        // Metadata travels intact
        drive_a(1'b1, 12'h00C, 1'b1, 12'h040, 32'h0000_0014);
        tick();
        check("meta_d_pc",   32'(qa.D_pc), 32'h00C);
        check("meta_bp",     32'(qa.D_BP_taken), 32'd1);
        check("meta_tgt",    32'(qa.D_BP_target_pc), 32'h040);
        check("meta_link",   qa.D_link_addr, 32'h0000_0014);
        check("meta_valid",  32'(qa.D_valid), 32'd1);

        // Stall fill: 6 offers, 4 accepted, D stable
        qa.stall_D = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int acc;
            acc = (i < 4) ? i : 4;
            check("fill_f_ready", 32'(qa.F_ready), (i < 4) ? 32'd1 : 32'd0);
            drive_a(1'b1, 12'(32'h10 + 4 * acc), 1'b0, 12'h0, 32'h0);
            tick();
            check("fill_d_pc", 32'(qa.D_pc), 32'h00C);
        end
        check("fill_count",   32'(qa.count), 32'd4);
        check("fill_f_ready", 32'(qa.F_ready), 32'd0);
        check("fill_d_bp",    32'(qa.D_BP_taken), 32'd1);

        // Release with fetch still offering 0x020: refused while full
        qa.stall_D = 1'b0;
        drive_a(1'b1, 12'h020, 1'b0, 12'h0, 32'h0);
        tick();
        check("full_d_pc",    32'(qa.D_pc), 32'h010);
        check("full_count",   32'(qa.count), 32'd3);
        check("full_f_ready", 32'(qa.F_ready), 32'd1);
        check("full_d_bp",    32'(qa.D_BP_taken), 32'd0);
        tick();
        check("pp_d_pc",  32'(qa.D_pc), 32'h014);
        check("pp_count", 32'(qa.count), 32'd3);
        drive_a(1'b0, 12'h0, 1'b0, 12'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drain_d_pc",  32'(qa.D_pc), 32'h018 + 32'(4 * i));
            check("drain_count", 32'(qa.count), 32'(2 - i));
        end
        check("drain_d_inst", qa.D_inst, 32'hA000_0020);

        // Flush during MEM_stall with 3 queued
        qa.MEM_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 12'(32'h30 + 4 * i), 1'b0, 12'h0, 32'h0);
            tick();
        end
        check("ms_count", 32'(qa.count), 32'd3);
        check("ms_d_pc",  32'(qa.D_pc), 32'h020);
        qa.EX_taken = 1'b1;
        drive_a(1'b1, 12'h03C, 1'b0, 12'h0, 32'h0);
        tick();
        qa.EX_taken = 1'b0;
        check("fl_d_valid", 32'(qa.D_valid), 32'd0);
        check("fl_d_inst",  qa.D_inst, NOP);
        check("fl_d_pc",    32'(qa.D_pc), 32'h0);
        check("fl_count",   32'(qa.count), 32'd0);
        check("fl_f_ready", 32'(qa.F_ready), 32'd1);
        qa.MEM_stall = 1'b0;
        drive_a(1'b1, 12'h100, 1'b0, 12'h0, 32'h0);
        tick();
        check("redir_d_pc",    32'(qa.D_pc), 32'h100);
        check("redir_d_valid", 32'(qa.D_valid), 32'd1);
        check("redir_count",   32'(qa.count), 32'd0);
        drive_a(1'b0, 12'h0, 1'b0, 12'h0, 32'h0);
        tick();
        check("post_fl_d_valid", 32'(qa.D_valid), 32'd0);
        check("post_fl_count",   32'(qa.count), 32'd0);

        // DEPTH = 3 wrap-around under alternating stalls
        begin
            int n;
            int prev_cnt;
            n        = 0;
            prev_cnt = 0;
            for (int c = 0; c < 13; c++) begin
                logic [11:0] pc;
                pc         = 12'(32'h200 + 4 * n);
                qb.stall_D = st_b[c][0];
                qb.F_valid = fv_b[c][0];
                qb.F_pc    = pc;
                qb.F_inst  = 32'hB000_0000 | 32'(pc);
                tick();
                check("wrap_d_valid", 32'(qb.D_valid), 32'(dv_b[c]));
                check("wrap_d_pc",    32'(qb.D_pc), 32'(dpc_b[c]));
                check("wrap_d_inst",  qb.D_inst,
                      (dv_b[c] != 0) ? (32'hB000_0000 | 32'(dpc_b[c])) : NOP);
                check("wrap_count",   32'(qb.count), 32'(cnt_b[c]));
                if (fv_b[c] != 0 && prev_cnt != 3) n++;
                prev_cnt = cnt_b[c];
            end
        end

        // Mid-stream reset
        rst        = 1'b1;
        qb.F_valid = 1'b1;
        qb.F_pc    = 12'h2F0;
        qb.F_inst  = 32'hB000_02F0;
        tick();
        rst = 1'b0;
        check("mrst_d_valid", 32'(qb.D_valid), 32'd0);
        check("mrst_d_inst",  qb.D_inst, NOP);
        check("mrst_d_pc",    32'(qb.D_pc), 32'h0);
        check("mrst_count",   32'(qb.count), 32'd0);
        check("mrst_f_ready", 32'(qb.F_ready), 32'd1);
        qb.stall_D = 1'b0;
        qb.F_pc    = 12'h300;
        qb.F_inst  = 32'hB000_0300;
        tick();
        check("mrst_byp_d_pc", 32'(qb.D_pc), 32'h300);
        check("mrst_byp_cnt",  32'(qb.count), 32'd0);
        qb.F_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Parametrised fetch-to-decode decoupling stage, replacing the single-entry F→D pipeline register. It buffers up to DEPTH fetched instructions, with their branch-prediction metadata, in a circular queue in front of a registered decode-output stage. The fetch side sees a ready/valid handshake, so fetch keeps running while decode or memory is stalled. A taken/mispredicted branch from EX flushes everything in the queue and output stage in one cycle.

## Interface
Parameters:
- XLEN, 32, instruction/link-address width
- PC_BITS, 12, PC width
- DEPTH, 4, queue entries (≥2, any integer; not required to be a power of two)
- NOP, 32'h2000_0000, instruction driven on D_inst for bubbles

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- F_valid  in  1  fetch presents an instruction
- F_ready  out  1  queue can accept: count != DEPTH
- F_pc  in  PC_BITS  fetched PC
- F_inst  in  XLEN  fetched instruction
- F_BP_taken  in  1  predictor taken
- F_BP_target_pc  in  PC_BITS  predicted target
- F_link_addr  in  XLEN  link address
- stall_D  in  1  decode hazard stall
- MEM_stall  in  1  memory stall
- EX_taken  in  1  redirect/flush from EX
- D_valid  out  1  D_* holds a real instruction
- D_pc, D_inst, D_BP_taken, D_BP_target_pc, D_link_addr  out  as F_*  decode-stage fields
- count  out  $clog2(DEPTH+1)  queue occupancy, excluding the output stage

## Operation
- State:
  - DEPTH-entry storage array
  - rd_ptr and wr_ptr, each 0..DEPTH-1, wrapping from DEPTH-1 to 0
  - count
  - D_* output registers
- Derived signals:
  - advance = !stall_D & !MEM_stall
  - push = F_valid & F_ready
- Priority order each cycle: rst > EX_taken > normal operation.
- rst or EX_taken:
  - rd_ptr = wr_ptr = count = 0
  - D_valid = 0, D_inst = NOP
  - D_pc, D_BP_target_pc and D_link_addr = 0; D_BP_taken = 0
  - An F push in the same cycle is discarded.
- Normal operation, advance = 1:
  - If count > 0: D_* loads entry[rd_ptr] with D_valid = 1, and rd_ptr increments (pop). If push is also high, F is written at wr_ptr.
  - If count == 0 and push: bypass. F loads D_* directly with D_valid = 1; nothing is written to the queue.
  - If count == 0 and no push: bubble. D_valid = 0, D_inst = NOP, other fields cleared as on reset.
- Normal operation, advance = 0:
  - D_* holds.
  - If push: F is written at wr_ptr and wr_ptr increments.
- Count update: count_next = count + (push & stored) − pop. "Stored" means push and not bypassed. Count never exceeds DEPTH and never goes below 0.
- F_ready depends only on registered count, not on this cycle's pop. A full queue therefore refuses a push even in a cycle where it pops.
- FIFO order is strict. Entry fields (pc, inst, BP_taken, BP_target_pc, link_addr) travel together.

## Timing
- Latency, empty queue: an F accepted at edge N is visible on D_* after edge N (1 cycle), if advance was high.
- Latency, non-empty queue: F reaches D after k+1 advancing cycles, where k is the number of entries ahead of it.
- Throughput: one instruction per cycle in steady state.
- Stall behaviour: with advance low, D_* is stable for the whole stall. Fetch may fill DEPTH entries, after which F_ready drops the cycle after count reaches DEPTH.
- Flush: EX_taken at edge N leaves D_valid = 0 and count = 0 after edge N, regardless of stall_D or MEM_stall. F_ready is 1 in the following cycle.
- Reset values: D_valid = 0, D_inst = NOP, every other D_* output = 0, count = 0, F_ready = 1.
- All outputs are registered except F_ready, which is combinational from count only.

## Test plan
- Reset, then stream PCs 0x000, 0x004, 0x008 with no stalls -> each appears on D_pc one cycle after acceptance with D_valid = 1; count stays 0 (bypass path).
- Hold stall_D = 1 with DEPTH = 4 and push 6 instructions -> 4 accepted; F_ready = 0 once count = 4; D_* unchanged. Release the stall -> D shows the 4 queued PCs in order over 4 cycles, then the resumed stream.
- Full queue with advance = 1 and F_valid = 1 -> F_ready = 0, so that cycle's push is refused. After the pop, count = 3 and F_ready = 1 the next cycle.
- Queue holding 3 entries, MEM_stall = 1, assert EX_taken for 1 cycle -> next cycle D_valid = 0, D_inst = NOP, count = 0. The redirected PC 0x100 pushed afterwards appears on D after one cycle.
- Empty queue, F_valid = 0, advance = 1 -> bubble: D_valid = 0, D_inst = NOP. Push F_BP_taken = 1, target 0x040, link 0x00000014 -> all fields appear intact on D.
- Wrap-around: run DEPTH = 3 through 10 push/pop cycles with alternating stalls -> output order matches input order exactly across pointer wrap; assert rst mid-stream -> all state returns to reset values the next cycle.
